// File: rtl/whack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : whack_pkg
//  Description : Shared types and constants for the whack-a-mole round
//                controller and its helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package whack_pkg;

    // Number of mole lanes on the board.
    localparam int LANES = 5;

    // Consecutive invalid RNG samples tolerated before falling back.
    localparam int MAX_RETRIES = 3;

    // Lane used when the RNG keeps returning non-one-hot values.
    localparam logic [LANES-1:0] FALLBACK_TARGET = 5'b00001;

    // Round controller states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SHOW    = 3'd3,
        ST_GAP     = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // True when exactly one bit of the (zero-extended) vector is set.
    function automatic logic is_onehot(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

endpackage : whack_pkg
`default_nettype wire

// File: rtl/button_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : button_edge_det
//  Description : Per-bit rising-edge detector. Keeps the previous sample of
//                a level bus and flags bits that went 0 -> 1 this cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_edge_det #(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] level_q;

    // Previous-cycle sample of the level bus, taken every cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level_q <= '0;
        end else begin
            level_q <= level;
        end
    end

    // A bit rises when it is high now and was low last cycle.
    always_comb begin
        rise = level & ~level_q;
    end

endmodule : button_edge_det
`default_nettype wire

// File: rtl/whack_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : whack_round_ctrl
//  Description : Game-round controller. Requests a one-hot mole from the RNG,
//                lights it for a hit window, judges button presses (with an
//                anti-mash rule) and tallies hits/misses over a game.
//  Options     : WHACK_DIFFICULTY_RAMP_EN - shrink the hit window after
//                each hit, down to a quarter of TIMEOUT_CYCLES.
//  Revision    : 1.0 - initial release
// ============================================================================
module whack_round_ctrl
    import whack_pkg::*;
#(
    parameter int LANES          = whack_pkg::LANES,
    parameter int ROUNDS         = 20,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int GAP_CYCLES     = 12500000,
    parameter int SCORE_W        = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [LANES-1:0]   target_onehot,
    input  logic [LANES-1:0]   buttons,
    output logic               gen_req,
    output logic [LANES-1:0]   mole_leds,
    output logic [SCORE_W-1:0] hits,
    output logic [SCORE_W-1:0] misses,
    output logic               busy,
    output logic               game_done
);

    localparam int TIMER_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    localparam int ROUND_W   = $clog2(ROUNDS + 1);
    localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD     = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX    = {SCORE_W{1'b1}};

    state_t             state, state_next;
    logic [LANES-1:0]   target, target_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [ROUND_W-1:0] round_cnt, round_next;
    logic [RETRY_W-1:0] retry_cnt, retry_next;
    logic               cap_wait, cap_wait_next;
    logic [SCORE_W-1:0] hits_next, misses_next;
    logic               game_done_next;
    logic [TIMER_W-1:0] window_load;
    logic [LANES-1:0]   edges;

`ifdef WHACK_DIFFICULTY_RAMP_EN
    localparam int WIN_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WIN_W-1:0] WIN_START = WIN_W'(TIMEOUT_CYCLES);
    localparam logic [WIN_W-1:0] WIN_STEP  = WIN_W'(TIMEOUT_CYCLES / 16);
    localparam logic [WIN_W-1:0] WIN_FLOOR = WIN_W'(TIMEOUT_CYCLES / 4);

    logic [WIN_W-1:0] window, window_next;

    // Current hit-window length; restarts at full length on every new game.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            window <= '0;
        end else begin
            window <= window_next;
        end
    end

    // Timer is loaded with one less than the window so SHOW lasts window cycles.
    always_comb begin
        window_load = TIMER_W'(window - WIN_W'(1));
    end
`else
    // Fixed window when the difficulty ramp is not built.
    always_comb begin
        window_load = TIMEOUT_LOAD;
    end
`endif

    button_edge_det #(
        .WIDTH (LANES)
    ) u_edge_det (
        .clock (clock),
        .reset (reset),
        .level (buttons),
        .rise  (edges)
    );

    // State and datapath registers; everything returns to zero on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            target    <= '0;
            timer     <= '0;
            round_cnt <= '0;
            retry_cnt <= '0;
            cap_wait  <= 1'b0;
            hits      <= '0;
            misses    <= '0;
            game_done <= 1'b0;
        end else begin
            state     <= state_next;
            target    <= target_next;
            timer     <= timer_next;
            round_cnt <= round_next;
            retry_cnt <= retry_next;
            cap_wait  <= cap_wait_next;
            hits      <= hits_next;
            misses    <= misses_next;
            game_done <= game_done_next;
        end
    end

    // Next-state logic and the per-state datapath updates.
    always_comb begin
        state_next     = state;
        target_next    = target;
        timer_next     = timer;
        round_next     = round_cnt;
        retry_next     = retry_cnt;
        cap_wait_next  = cap_wait;
        hits_next      = hits;
        misses_next    = misses;
        game_done_next = 1'b0;
`ifdef WHACK_DIFFICULTY_RAMP_EN
        window_next    = window;
`endif

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    hits_next   = '0;
                    misses_next = '0;
                    round_next  = '0;
                    state_next  = ST_REQUEST;
`ifdef WHACK_DIFFICULTY_RAMP_EN
                    window_next = WIN_START;
`endif
                end
            end

            ST_REQUEST: begin
                // The RNG advances on this cycle's strobe; skip one cycle
                // before trusting its output.
                cap_wait_next = 1'b1;
                state_next    = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                if (cap_wait) begin
                    cap_wait_next = 1'b0;
                end else if (is_onehot(32'(target_onehot))) begin
                    target_next = target_onehot;
                    timer_next  = window_load;
                    retry_next  = '0;
                    state_next  = ST_SHOW;
                end else if (retry_cnt == RETRY_W'(MAX_RETRIES - 1)) begin
                    // RNG looks stuck; keep the game moving on a known lane.
                    target_next = LANES'(FALLBACK_TARGET);
                    timer_next  = window_load;
                    retry_next  = '0;
                    state_next  = ST_SHOW;
                end else begin
                    retry_next = retry_cnt + RETRY_W'(1);
                    state_next = ST_REQUEST;
                end
            end

            ST_SHOW: begin
                // Press judgement outranks timeout; any wrong-lane edge is a
                // miss even if the target lane rose in the same cycle.
                if ((edges & ~target) != '0) begin
                    if (misses != SCORE_MAX) begin
                        misses_next = misses + SCORE_W'(1);
                    end
                    timer_next = GAP_LOAD;
                    state_next = ST_GAP;
                end else if ((edges & target) != '0) begin
                    if (hits != SCORE_MAX) begin
                        hits_next = hits + SCORE_W'(1);
                    end
`ifdef WHACK_DIFFICULTY_RAMP_EN
                    if (window >= WIN_FLOOR + WIN_STEP) begin
                        window_next = window - WIN_STEP;
                    end else begin
                        window_next = WIN_FLOOR;
                    end
`endif
                    timer_next = GAP_LOAD;
                    state_next = ST_GAP;
                end else if (timer == '0) begin
                    if (misses != SCORE_MAX) begin
                        misses_next = misses + SCORE_W'(1);
                    end
                    timer_next = GAP_LOAD;
                    state_next = ST_GAP;
                end else begin
                    timer_next = timer - TIMER_W'(1);
                end
            end

            ST_GAP: begin
                if (timer == '0) begin
                    round_next = round_cnt + ROUND_W'(1);
                    if (round_next == ROUND_W'(ROUNDS)) begin
                        game_done_next = 1'b1;
                        state_next     = ST_DONE;
                    end else begin
                        state_next = ST_REQUEST;
                    end
                end else begin
                    timer_next = timer - TIMER_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs; they drop as soon as reset forces IDLE.
    always_comb begin
        gen_req   = (state == ST_REQUEST);
        mole_leds = (state == ST_SHOW) ? target : '0;
        busy      = (state != ST_IDLE) && (state != ST_DONE);
    end

endmodule : whack_round_ctrl
`default_nettype wire
